// File: rtl/hex_telemetry_framer.sv
// rtl/hex_telemetry_framer.sv - periodic ASCII-hex telemetry frame generator for a UART byte transmitter
//
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   ch_data       : NCH channel values of DW bits each, channel 0 in the LSBs
//   force_send    : request a frame at the next opportunity even if data is unchanged
//   tx_busy       : busy flag from the byte transmitter
//   tx_start      : one-cycle byte-start strobe to the transmitter
//   tx_data       : byte to send, valid while tx_start is high, 0x00 otherwise
//   frame_active  : high from snapshot until the last byte of the frame is accepted
//   frame_count   : completed frames, wraps at 16 bits
module hex_telemetry_framer #(
    parameter int NCH         = 4,
    parameter int DW          = 12,
    parameter int PERIOD      = 1024,
    parameter int CHANGE_ONLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic              force_send,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              frame_active,
    output logic [15:0]       frame_count
);

    localparam int NDIG = DW / 4;
    localparam int FLEN = NCH * NDIG + NCH + 1;
    localparam int IW   = $clog2(FLEN);
    localparam int CW   = $clog2(NCH + 1);
    localparam int PW   = $clog2(NDIG + 1);
    localparam int TW   = $clog2(PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        ISSUE,
        GUARD,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [TW-1:0]     opp_cnt;
    logic              tick;
    logic [NCH*DW-1:0] frame_buf;
    logic [NCH*DW-1:0] last_sent;
    logic              pending;
    logic              changed;
    logic [IW-1:0]     byte_idx;
    // ch_sel/pos_sel walk the frame alongside byte_idx so the byte mux needs
    // no division: pos_sel == NDIG is the separator slot after a channel, and
    // ch_sel == NCH is the trailing line feed.
    logic [CW-1:0]     ch_sel;
    logic [PW-1:0]     pos_sel;
    logic              last_byte;
    logic [31:0]       shamt;
    logic [3:0]        nib;
    logic [7:0]        hex_char;
    logic [7:0]        cur_byte;

    // Opportunity counter runs continuously, frames in flight or not.
    assign tick = (opp_cnt == TW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opp_cnt <= '0;
        end else if (tick) begin
            opp_cnt <= '0;
        end else begin
            opp_cnt <= opp_cnt + TW'(1);
        end
    end

    assign changed   = (CHANGE_ONLY == 0) || (ch_data != last_sent);
    assign last_byte = (byte_idx == IW'(FLEN - 1));

    // Byte generator, driven only from the frame buffer.
    always_comb begin
        shamt    = 32'(ch_sel) * 32'(DW) + 32'(DW - 4) - 32'(pos_sel) * 32'd4;
        nib      = 4'(frame_buf >> shamt);
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        if (ch_sel == CW'(NCH)) begin
            cur_byte = 8'h0A;
        end else if (pos_sel == PW'(NDIG)) begin
            cur_byte = (ch_sel == CW'(NCH - 1)) ? 8'h0D : 8'h20;
        end else begin
            cur_byte = hex_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        frame_active = (state != IDLE);
        case (state)
            IDLE: begin
                if (tick && (changed || pending)) begin
                    state_nxt = SNAP;
                end
            end
            SNAP: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    tx_data   = cur_byte;
                    state_nxt = GUARD;
                end
            end
            // The transmitter raises busy one cycle after the strobe, so busy
            // is not trusted during this cycle.
            GUARD: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_nxt = last_byte ? IDLE : ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_buf   <= '0;
            last_sent   <= '0;
            pending     <= 1'b0;
            byte_idx    <= '0;
            ch_sel      <= '0;
            pos_sel     <= '0;
            frame_count <= 16'h0000;
        end else begin
            // A request arriving in the snapshot cycle belongs to the next
            // frame, so set takes priority over clear.
            if (force_send) begin
                pending <= 1'b1;
            end else if (state == SNAP) begin
                pending <= 1'b0;
            end

            if (state == SNAP) begin
                frame_buf <= ch_data;
                last_sent <= ch_data;
                byte_idx  <= '0;
                ch_sel    <= '0;
                pos_sel   <= '0;
            end

            if (state == DRAIN && !tx_busy) begin
                if (last_byte) begin
                    frame_count <= frame_count + 16'd1;
                end else begin
                    byte_idx <= byte_idx + IW'(1);
                    if (pos_sel == PW'(NDIG)) begin
                        pos_sel <= '0;
                        ch_sel  <= ch_sel + CW'(1);
                    end else begin
                        pos_sel <= pos_sel + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_telemetry_framer.sv
// tb/tb_hex_telemetry_framer.sv - scoreboard bench for hex_telemetry_framer
module tb_hex_telemetry_framer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_b;
    logic [47:0] ch_a;
    logic [31:0] ch_b;
    logic        force_a, force_b, hold_busy;
    int          bcnt_a, bcnt_b;
    logic        busy_a, busy_b;
    logic        tx_start_a, tx_start_b, active_a, active_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic [15:0] fc_a, fc_b;

    int          total = 0;
    int          bad = 0;
    int          strobes_a = 0, strobes_b = 0;
    int          gap_a = 100, gap_b = 100;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];

    assign busy_a = (bcnt_a != 0) || hold_busy;
    assign busy_b = (bcnt_b != 0);

    hex_telemetry_framer #(.NCH(4), .DW(12), .PERIOD(256), .CHANGE_ONLY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_a), .force_send(force_a), .tx_busy(busy_a),
        .tx_start(tx_start_a), .tx_data(tx_data_a), .frame_active(active_a), .frame_count(fc_a)
    );

    hex_telemetry_framer #(.NCH(2), .DW(16), .PERIOD(200), .CHANGE_ONLY(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .ch_data(ch_b), .force_send(force_b), .tx_busy(busy_b),
        .tx_start(tx_start_b), .tx_data(tx_data_b), .frame_active(active_b), .frame_count(fc_b)
    );

    // Transmitter models: busy for 10 cycles starting the cycle after a strobe.
    always @(posedge clk) begin
        if (!rst_n) bcnt_a <= 0;
        else if (tx_start_a) bcnt_a <= 10;
        else if (bcnt_a > 0) bcnt_a <= bcnt_a - 1;
        if (!rst_b) bcnt_b <= 0;
        else if (tx_start_b) bcnt_b <= 10;
        else if (bcnt_b > 0) bcnt_b <= bcnt_b - 1;
    end

    // Output monitors: pop the scoreboard on every strobe.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            gap_a = 100;
        end else begin
            gap_a++;
            total++;
            if (tx_start_a) begin
                if (exp_a.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected_byte: got %02h, no byte expected", tx_data_a);
                end else begin
                    e = exp_a.pop_front();
                    if (tx_data_a !== e) begin
                        bad++;
                        $display("FAIL a_byte: got %02h expected %02h", tx_data_a, e);
                    end
                end
                total++;
                if (gap_a < 3) begin
                    bad++;
                    $display("FAIL a_strobe_gap: got %0d expected >=3", gap_a);
                end
                gap_a = 0;
                strobes_a++;
            end else if (tx_data_a !== 8'h00) begin
                bad++;
                $display("FAIL a_idle_data: got %02h expected 00", tx_data_a);
            end
        end
        if (!rst_b) begin
            gap_b = 100;
        end else begin
            gap_b++;
            total++;
            if (tx_start_b) begin
                if (exp_b.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected_byte: got %02h, no byte expected", tx_data_b);
                end else begin
                    e = exp_b.pop_front();
                    if (tx_data_b !== e) begin
                        bad++;
                        $display("FAIL b_byte: got %02h expected %02h", tx_data_b, e);
                    end
                end
                total++;
                if (gap_b < 3) begin
                    bad++;
                    $display("FAIL b_strobe_gap: got %0d expected >=3", gap_b);
                end
                gap_b = 0;
                strobes_b++;
            end else if (tx_data_b !== 8'h00) begin
                bad++;
                $display("FAIL b_idle_data: got %02h expected 00", tx_data_b);
            end
        end
    end

    task automatic push_frame(input bit to_b, input int nch, input int dw, input logic [63:0] d);
        logic [7:0] b;
        logic [3:0] nb;
        for (int c = 0; c < nch; c++) begin
            for (int n = dw / 4 - 1; n >= 0; n--) begin
                nb = d[c * dw + n * 4 +: 4];
                b  = (nb < 4'd10) ? (8'h30 + {4'h0, nb}) : (8'h41 + {4'h0, nb} - 8'd10);
                if (to_b) exp_b.push_back(b); else exp_a.push_back(b);
            end
            if (c < nch - 1) begin
                if (to_b) exp_b.push_back(8'h20); else exp_a.push_back(8'h20);
            end
        end
        if (to_b) begin exp_b.push_back(8'h0D); exp_b.push_back(8'h0A); end
        else begin exp_a.push_back(8'h0D); exp_a.push_back(8'h0A); end
    endtask

    task automatic wait_fc_a(input logic [15:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fc_a == target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_strobes_a(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (strobes_a >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_force_a();
        @(negedge clk);
        force_a = 1'b1;
        @(negedge clk);
        force_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_b = 1'b0;
        ch_a = 48'h0; ch_b = 32'h0;
        force_a = 1'b0; force_b = 1'b0; hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx_start_a !== 1'b0 || tx_data_a !== 8'h00 || active_a !== 1'b0 || fc_a !== 16'h0) begin
            bad++;
            $display("FAIL reset_a: start=%b data=%02h active=%b count=%0d expected 0/00/0/0",
                     tx_start_a, tx_data_a, active_a, fc_a);
        end
        total++;
        if (tx_start_b !== 1'b0 || tx_data_b !== 8'h00 || active_b !== 1'b0 || fc_b !== 16'h0) begin
            bad++;
            $display("FAIL reset_b: start=%b data=%02h active=%b count=%0d expected 0/00/0/0",
                     tx_start_b, tx_data_b, active_b, fc_b);
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        int s0;
        ch_a = {12'hFFF, 12'h0F0, 12'h123, 12'hABC};
        push_frame(1'b0, 4, 12, 64'(ch_a));
        s0 = strobes_a;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fc_a(16'd1, 700, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: count=%0d expected 1", fc_a); end
        total++;
        if (strobes_a - s0 != 17) begin
            bad++; $display("FAIL basic_strobes: got %0d expected 17", strobes_a - s0);
        end
        total++;
        if (exp_a.size() != 0 || active_a !== 1'b0) begin
            bad++; $display("FAIL basic_done: left=%0d active=%b expected 0/0", exp_a.size(), active_a);
        end
    endtask

    task automatic test_change_only();
        bit ok;
        int s0;
        s0 = strobes_a;
        repeat (800) @(negedge clk);
        total++;
        if (strobes_a != s0) begin
            bad++; $display("FAIL unchanged_quiet: got %0d strobes expected 0", strobes_a - s0);
        end
        push_frame(1'b0, 4, 12, 64'(ch_a));
        pulse_force_a();
        wait_fc_a(16'd2, 600, ok);
        total++;
        if (!ok || strobes_a - s0 != 17 || exp_a.size() != 0) begin
            bad++;
            $display("FAIL force_frame: count=%0d strobes=%0d left=%0d expected 2/17/0",
                     fc_a, strobes_a - s0, exp_a.size());
        end
        repeat (300) @(negedge clk);
        total++;
        if (strobes_a - s0 != 17) begin
            bad++; $display("FAIL force_once: got %0d strobes expected 17", strobes_a - s0);
        end
    endtask

    task automatic test_mid_frame_change();
        bit ok;
        int s0;
        s0 = strobes_a;
        push_frame(1'b0, 4, 12, 64'(ch_a));
        pulse_force_a();
        wait_strobes_a(s0 + 5, 600, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midchange_start: strobes=%0d expected 5", strobes_a - s0); end
        ch_a[11:0] = 12'h456;
        push_frame(1'b0, 4, 12, 64'(ch_a));
        wait_fc_a(16'd4, 1000, ok);
        total++;
        if (!ok || exp_a.size() != 0 || strobes_a - s0 != 34) begin
            bad++;
            $display("FAIL midchange_frames: count=%0d left=%0d strobes=%0d expected 4/0/34",
                     fc_a, exp_a.size(), strobes_a - s0);
        end
    endtask

    task automatic test_busy_hold();
        bit ok;
        int s0;
        hold_busy = 1'b1;
        ch_a[23:12] = 12'h789;
        push_frame(1'b0, 4, 12, 64'(ch_a));
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (active_a) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL hold_start: active=%b expected 1", active_a); end
        s0 = strobes_a;
        repeat (500) @(negedge clk);
        total++;
        if (strobes_a != s0 || active_a !== 1'b1) begin
            bad++;
            $display("FAIL hold_quiet: strobes=%0d active=%b expected 0/1", strobes_a - s0, active_a);
        end
        @(posedge clk);
        #1 hold_busy = 1'b0;
        @(negedge clk);
        total++;
        if (tx_start_a !== 1'b1) begin
            bad++; $display("FAIL hold_release: start=%b expected 1", tx_start_a);
        end
        wait_fc_a(16'd5, 400, ok);
        total++;
        if (!ok || exp_a.size() != 0 || strobes_a - s0 != 17) begin
            bad++;
            $display("FAIL hold_frame: count=%0d left=%0d strobes=%0d expected 5/0/17",
                     fc_a, exp_a.size(), strobes_a - s0);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int s0;
        s0 = strobes_a;
        ch_a[35:24] = 12'h321;
        push_frame(1'b0, 4, 12, 64'(ch_a));
        wait_strobes_a(s0 + 8, 600, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_start: strobes=%0d expected 8", strobes_a - s0); end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (tx_start_a) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_byte8: start=%b expected 1", tx_start_a); end
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_start_a !== 1'b0 || tx_data_a !== 8'h00 || active_a !== 1'b0 || fc_a !== 16'h0) begin
            bad++;
            $display("FAIL rstmid_abort: start=%b data=%02h active=%b count=%0d expected 0/00/0/0",
                     tx_start_a, tx_data_a, active_a, fc_a);
        end
        exp_a.delete();
        push_frame(1'b0, 4, 12, 64'(ch_a));
        s0 = strobes_a;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_fc_a(16'd1, 600, ok);
        total++;
        if (!ok || exp_a.size() != 0 || strobes_a - s0 != 17) begin
            bad++;
            $display("FAIL rstmid_refill: count=%0d left=%0d strobes=%0d expected 1/0/17",
                     fc_a, exp_a.size(), strobes_a - s0);
        end
    endtask

    task automatic test_two_channel_always();
        bit ok;
        ch_b = {16'h1234, 16'h00FF};
        for (int f = 0; f < 3; f++) push_frame(1'b1, 2, 16, 64'(ch_b));
        @(negedge clk);
        rst_b = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fc_b == 16'd3) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || exp_b.size() != 0 || strobes_b != 33) begin
            bad++;
            $display("FAIL nch2_frames: count=%0d left=%0d strobes=%0d expected 3/0/33",
                     fc_b, exp_b.size(), strobes_b);
        end
        rst_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_change_only();
        test_mid_frame_change();
        test_busy_hold();
        test_reset_mid_frame();
        test_two_channel_always();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
